// File: rtl/l2_cache_nway_if.sv
// l2_cache_nway_if: upstream (L1 side) and physical-memory block bus of the L2 cache.
// The cache uses the slave modport; the requester/memory environment uses master.
interface l2_cache_nway_if #(
    parameter int unsigned BLOCK_BITS = 128
);
    logic                  mem_read;
    logic                  mem_write;
    logic [15:0]           mem_address;
    logic [BLOCK_BITS-1:0] mem_wdata;
    logic [BLOCK_BITS-1:0] mem_rdata;
    logic                  mem_resp;
    logic                  pmem_read;
    logic                  pmem_write;
    logic [15:0]           pmem_address;
    logic [BLOCK_BITS-1:0] pmem_wdata;
    logic [BLOCK_BITS-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata,
        input  mem_rdata, mem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata,
        output mem_rdata, mem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/l2_cache_nway.sv
// l2_cache_nway: N-way set-associative, write-back, write-allocate L2 cache with
// tree pseudo-LRU replacement and invalid-way-first victim selection.
// Optional performance counters are built when L2_PERF_COUNTERS_EN is defined;
// otherwise hit_count/miss_count/wb_count are tied to zero.
module l2_cache_nway #(
    parameter int unsigned WAYS       = 4,
    parameter int unsigned LOG_SETS   = 3,
    parameter int unsigned BLOCK_BITS = 128
) (
    input  logic                clk,
    input  logic                reset,
    l2_cache_nway_if.slave      bus,
    output logic [15:0]         hit_count,
    output logic [15:0]         miss_count,
    output logic [15:0]         wb_count
);
    localparam int unsigned OFF  = $clog2(BLOCK_BITS / 8);
    localparam int unsigned TAG  = 16 - LOG_SETS - OFF;
    localparam int unsigned SETS = 1 << LOG_SETS;
    localparam int unsigned WLOG = $clog2(WAYS);

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t state, state_next;

    logic [BLOCK_BITS-1:0] data_arr  [SETS][WAYS];
    logic [TAG-1:0]        tag_arr   [SETS][WAYS];
    logic [WAYS-1:0]       valid_arr [SETS];
    logic [WAYS-1:0]       dirty_arr [SETS];
    logic [WAYS-2:0]       plru_arr  [SETS];

    logic [TAG-1:0]      req_tag;
    logic [LOG_SETS-1:0] req_idx;
    logic                req_any;
    logic                hit;
    logic [WLOG-1:0]     hit_way;
    logic [WLOG-1:0]     victim_sel;
    logic [WLOG-1:0]     victim_q;
    logic                do_hit;
    logic                do_miss;
    logic                do_wb_done;
    logic                do_fill;

    // Walk the tree from the root; heap layout, node n has children 2n+1 (left) and 2n+2.
    function automatic logic [WLOG-1:0] plru_victim(input logic [WAYS-2:0] b);
        int unsigned pre;
        int unsigned node;
        pre = 0;
        for (int unsigned l = 0; l < WLOG; l++) begin
            node = ((32'd1 << l) - 32'd1) + pre;
            pre  = 2 * pre + (b[node] ? 32'd1 : 32'd0);
        end
        return WLOG'(pre);
    endfunction

    // Point every node on the path of the touched way towards the other subtree.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] b,
                                                   input logic [WLOG-1:0] w);
        logic [WAYS-2:0] r;
        int unsigned node;
        r = b;
        for (int unsigned l = 0; l < WLOG; l++) begin
            node    = ((32'd1 << l) - 32'd1) + (32'(w) >> (WLOG - l));
            r[node] = ~w[WLOG-1-l];
        end
        return r;
    endfunction

    assign req_tag = bus.mem_address[15:16-TAG];
    assign req_idx = bus.mem_address[LOG_SETS+OFF-1:OFF];
    assign req_any = bus.mem_read | bus.mem_write;

    // Tag compare across the set; the lowest matching way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = WAYS; w > 0; w--) begin
            if (valid_arr[req_idx][w-1] && (tag_arr[req_idx][w-1] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WLOG'(w - 1);
            end
        end
    end

    // Victim choice: lowest invalid way, else the pseudo-LRU way.
    always_comb begin
        victim_sel = plru_victim(plru_arr[req_idx]);
        for (int unsigned w = WAYS; w > 0; w--) begin
            if (!valid_arr[req_idx][w-1]) begin
                victim_sel = WLOG'(w - 1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and bus outputs.
    always_comb begin
        state_next        = state;
        bus.mem_resp      = 1'b0;
        bus.pmem_read     = 1'b0;
        bus.pmem_write    = 1'b0;
        bus.pmem_address  = '0;
        bus.mem_rdata     = data_arr[req_idx][hit_way];
        bus.pmem_wdata    = data_arr[req_idx][victim_q];
        do_hit            = 1'b0;
        do_miss           = 1'b0;
        do_wb_done        = 1'b0;
        do_fill           = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_any) begin
                    if (hit) begin
                        bus.mem_resp = 1'b1;
                        do_hit       = 1'b1;
                    end else begin
                        do_miss = 1'b1;
                        if (valid_arr[req_idx][victim_sel] && dirty_arr[req_idx][victim_sel]) begin
                            state_next = WRITEBACK;
                        end else begin
                            state_next = ALLOCATE;
                        end
                    end
                end
            end
            WRITEBACK: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag_arr[req_idx][victim_q], req_idx, {OFF{1'b0}}};
                if (bus.pmem_resp) begin
                    do_wb_done = 1'b1;
                    state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {bus.mem_address[15:OFF], {OFF{1'b0}}};
                if (bus.pmem_resp) begin
                    do_fill    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Valid/dirty/PLRU state and the victim latched at the miss edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
                plru_arr[s]  <= '0;
            end
            victim_q <= '0;
        end else begin
            if (do_miss) begin
                victim_q <= victim_sel;
            end
            if (do_hit) begin
                plru_arr[req_idx] <= plru_touch(plru_arr[req_idx], hit_way);
                if (bus.mem_write) begin
                    dirty_arr[req_idx][hit_way] <= 1'b1;
                end
            end
            if (do_wb_done) begin
                dirty_arr[req_idx][victim_q] <= 1'b0;
            end
            if (do_fill) begin
                valid_arr[req_idx][victim_q] <= 1'b1;
                dirty_arr[req_idx][victim_q] <= 1'b0;
                plru_arr[req_idx]            <= plru_touch(plru_arr[req_idx], victim_q);
            end
        end
    end

    // Data and tag storage; not reset, since valid bits gate every use.
    always_ff @(posedge clk) begin
        if (do_hit && bus.mem_write) begin
            data_arr[req_idx][hit_way] <= bus.mem_wdata;
        end
        if (do_fill) begin
            data_arr[req_idx][victim_q] <= bus.pmem_rdata;
            tag_arr[req_idx][victim_q]  <= req_tag;
        end
    end

`ifdef L2_PERF_COUNTERS_EN
    logic missed;

    // Saturating hit/miss/writeback counters; a miss's final mem_resp is not a hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            missed     <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (do_miss) begin
                missed <= 1'b1;
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
            if (do_hit) begin
                missed <= 1'b0;
                if (!missed && (hit_count != 16'hFFFF)) hit_count <= hit_count + 16'd1;
            end
            if (do_wb_done && (wb_count != 16'hFFFF)) begin
                wb_count <= wb_count + 16'd1;
            end
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_l2_cache_nway.sv
// tb_l2_cache_nway: directed, table-driven bench for l2_cache_nway (default parameters)
// with a small block-memory model behind the pmem port.
module tb_l2_cache_nway;
    logic        clk;
    logic        reset;
    logic [15:0] hit_count, miss_count, wb_count;

    l2_cache_nway_if #(.BLOCK_BITS(128)) bus ();

    l2_cache_nway #(.WAYS(4), .LOG_SETS(3), .BLOCK_BITS(128)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int both_cnt = 0;

    logic [127:0] mem_model [logic [15:0]];

    function automatic logic [127:0] blk(input logic [15:0] a);
        return {8{a}} ^ {4{32'hA5C3_0F96}};
    endfunction

    function automatic logic [127:0] mem_rd(input logic [15:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return blk(a);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.pmem_resp = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // One upstream transaction; acts as memory until mem_resp or the cycle budget expires.
    task automatic access(input logic wr, input logic [15:0] a, input logic [127:0] wd,
                          output int cycles, output logic wb, output logic [15:0] wb_a,
                          output logic [127:0] wb_d, output logic [15:0] fill_a,
                          output logic [127:0] rd);
        logic ok;
        bus.mem_read    = ~wr;
        bus.mem_write   = wr;
        bus.mem_address = a;
        bus.mem_wdata   = wd;
        ok = 1'b0; wb = 1'b0; wb_a = '0; wb_d = '0; fill_a = '0; rd = '0;
        cycles = 99;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.pmem_read && bus.pmem_write) both_cnt++;
            if (bus.mem_resp) begin
                rd = bus.mem_rdata;
                ok = 1'b1;
                cycles = c;
            end else if (bus.pmem_write) begin
                wb   = 1'b1;
                wb_a = bus.pmem_address;
                wb_d = bus.pmem_wdata;
                mem_model[wb_a] = wb_d;
                bus.pmem_resp = 1'b1;
            end else if (bus.pmem_read) begin
                fill_a = bus.pmem_address;
                bus.pmem_rdata = mem_rd(fill_a);
                bus.pmem_resp = 1'b1;
            end
            @(posedge clk);
            #1 bus.pmem_resp = 1'b0;
            if (ok) break;
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    typedef struct {
        logic         rst;
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
        int           cyc;
        logic         wb;
        logic [15:0]  wb_addr;
        logic [127:0] wb_data;
        logic [15:0]  fill_addr;
        logic         chk_rd;
        logic [127:0] rdata;
    } vec_t;

    function automatic vec_t mkv(input logic rst, input logic wr, input logic [15:0] addr,
                                 input logic [127:0] wdata, input int cyc, input logic wb,
                                 input logic [15:0] wb_addr, input logic [127:0] wb_data,
                                 input logic [15:0] fill_addr, input logic chk_rd,
                                 input logic [127:0] rdata);
        vec_t v;
        v.rst = rst; v.wr = wr; v.addr = addr; v.wdata = wdata; v.cyc = cyc;
        v.wb = wb; v.wb_addr = wb_addr; v.wb_data = wb_data; v.fill_addr = fill_addr;
        v.chk_rd = chk_rd; v.rdata = rdata;
        return v;
    endfunction

    localparam logic [127:0] DB = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
    localparam logic [127:0] DC = 128'hCCCC_1111_CCCC_2222_CCCC_3333_CCCC_4444;

    vec_t vecs [22];

    int           cyc;
    logic         wb;
    logic [15:0]  wb_a, fill_a;
    logic [127:0] wb_d, rd;

    initial begin
        reset = 1'b1;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_address = '0;
        bus.mem_wdata = '0; bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;

        //               rst   wr    addr      wdata cyc wb    wb_addr   wb_data fill      chk   rdata
        vecs[0]  = mkv(1'b1, 1'b0, 16'h1230, '0, 3, 1'b0, 16'h0000, '0, 16'h1230, 1'b1, blk(16'h1230));
        vecs[1]  = mkv(1'b0, 1'b0, 16'h1230, '0, 1, 1'b0, 16'h0000, '0, 16'h0000, 1'b1, blk(16'h1230));
        vecs[2]  = mkv(1'b1, 1'b0, 16'h0030, '0, 3, 1'b0, 16'h0000, '0, 16'h0030, 1'b1, blk(16'h0030));
        vecs[3]  = mkv(1'b0, 1'b0, 16'h00B0, '0, 3, 1'b0, 16'h0000, '0, 16'h00B0, 1'b1, blk(16'h00B0));
        vecs[4]  = mkv(1'b0, 1'b0, 16'h0130, '0, 3, 1'b0, 16'h0000, '0, 16'h0130, 1'b1, blk(16'h0130));
        vecs[5]  = mkv(1'b0, 1'b0, 16'h01B0, '0, 3, 1'b0, 16'h0000, '0, 16'h01B0, 1'b1, blk(16'h01B0));
        vecs[6]  = mkv(1'b0, 1'b0, 16'h0230, '0, 3, 1'b0, 16'h0000, '0, 16'h0230, 1'b1, blk(16'h0230));
        vecs[7]  = mkv(1'b0, 1'b0, 16'h0030, '0, 3, 1'b0, 16'h0000, '0, 16'h0030, 1'b1, blk(16'h0030));
        vecs[8]  = mkv(1'b1, 1'b0, 16'h0030, '0, 3, 1'b0, 16'h0000, '0, 16'h0030, 1'b1, blk(16'h0030));
        vecs[9]  = mkv(1'b0, 1'b0, 16'h00B0, '0, 3, 1'b0, 16'h0000, '0, 16'h00B0, 1'b1, blk(16'h00B0));
        vecs[10] = mkv(1'b0, 1'b0, 16'h0130, '0, 3, 1'b0, 16'h0000, '0, 16'h0130, 1'b1, blk(16'h0130));
        vecs[11] = mkv(1'b0, 1'b0, 16'h01B0, '0, 3, 1'b0, 16'h0000, '0, 16'h01B0, 1'b1, blk(16'h01B0));
        vecs[12] = mkv(1'b0, 1'b1, 16'h00B0, DB, 1, 1'b0, 16'h0000, '0, 16'h0000, 1'b0, '0);
        vecs[13] = mkv(1'b0, 1'b0, 16'h0030, '0, 1, 1'b0, 16'h0000, '0, 16'h0000, 1'b1, blk(16'h0030));
        vecs[14] = mkv(1'b0, 1'b0, 16'h0130, '0, 1, 1'b0, 16'h0000, '0, 16'h0000, 1'b1, blk(16'h0130));
        vecs[15] = mkv(1'b0, 1'b0, 16'h01B0, '0, 1, 1'b0, 16'h0000, '0, 16'h0000, 1'b1, blk(16'h01B0));
        vecs[16] = mkv(1'b0, 1'b0, 16'h0230, '0, 4, 1'b1, 16'h00B0, DB, 16'h0230, 1'b1, blk(16'h0230));
        vecs[17] = mkv(1'b0, 1'b0, 16'h00B0, '0, 3, 1'b0, 16'h0000, '0, 16'h00B0, 1'b1, DB);
        vecs[18] = mkv(1'b0, 1'b1, 16'h0330, DC, 3, 1'b0, 16'h0000, '0, 16'h0330, 1'b0, '0);
        vecs[19] = mkv(1'b0, 1'b0, 16'h033F, '0, 1, 1'b0, 16'h0000, '0, 16'h0000, 1'b1, DC);
        vecs[20] = mkv(1'b0, 1'b0, 16'hFFF7, '0, 3, 1'b0, 16'h0000, '0, 16'hFFF0, 1'b1, blk(16'hFFF0));
        vecs[21] = mkv(1'b0, 1'b0, 16'hFFFF, '0, 1, 1'b0, 16'h0000, '0, 16'h0000, 1'b1, blk(16'hFFF0));

        // Reset state with no request pending.
        do_reset();
        @(negedge clk);
        chk("rst_mem_resp",   128'(bus.mem_resp),     128'(0));
        chk("rst_pmem_read",  128'(bus.pmem_read),    128'(0));
        chk("rst_pmem_write", 128'(bus.pmem_write),   128'(0));
        chk("rst_pmem_addr",  128'(bus.pmem_address), 128'(0));
        chk("rst_hit_count",  128'(hit_count),        128'(0));
        @(posedge clk); #1;

        for (int i = 0; i < 22; i++) begin
            if (vecs[i].rst) do_reset();
            access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, cyc, wb, wb_a, wb_d, fill_a, rd);
            chk($sformatf("v%0d_cycles", i), 128'(cyc), 128'(vecs[i].cyc));
            chk($sformatf("v%0d_wb", i), 128'(wb), 128'(vecs[i].wb));
            if (vecs[i].wb) begin
                chk($sformatf("v%0d_wb_addr", i), 128'(wb_a), 128'(vecs[i].wb_addr));
                chk($sformatf("v%0d_wb_data", i), wb_d, vecs[i].wb_data);
            end
            if (vecs[i].cyc > 1) chk($sformatf("v%0d_fill_addr", i), 128'(fill_a), 128'(vecs[i].fill_addr));
            if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
        end

        // Reset during ALLOCATE: pmem_read drops at once; the held read misses again.
        do_reset();
        bus.mem_read = 1'b1; bus.mem_address = 16'h1230;
        @(negedge clk);
        @(negedge clk);
        chk("alloc_pmem_read", 128'(bus.pmem_read), 128'(1));
        chk("alloc_pmem_addr", 128'(bus.pmem_address), 128'(16'h1230));
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_pmem_read", 128'(bus.pmem_read), 128'(0));
        chk("rst_mid_pmem_addr", 128'(bus.pmem_address), 128'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        access(1'b0, 16'h1230, '0, cyc, wb, wb_a, wb_d, fill_a, rd);
        chk("rst_mid_cycles", 128'(cyc), 128'(3));
        chk("rst_mid_fill", 128'(fill_a), 128'(16'h1230));
        chk("rst_mid_rdata", rd, blk(16'h1230));

        // Counters after one miss and one hit; stray pmem_resp in IDLE is ignored.
        do_reset();
        access(1'b0, 16'h1230, '0, cyc, wb, wb_a, wb_d, fill_a, rd);
        access(1'b0, 16'h1230, '0, cyc, wb, wb_a, wb_d, fill_a, rd);
        @(negedge clk);
`ifdef L2_PERF_COUNTERS_EN
        chk("cnt_hit",  128'(hit_count),  128'(1));
        chk("cnt_miss", 128'(miss_count), 128'(1));
        chk("cnt_wb",   128'(wb_count),   128'(0));
`else
        chk("cnt_hit",  128'(hit_count),  128'(0));
        chk("cnt_miss", 128'(miss_count), 128'(0));
        chk("cnt_wb",   128'(wb_count),   128'(0));
`endif
        bus.pmem_resp = 1'b1;
        @(posedge clk);
        #1 bus.pmem_resp = 1'b0;
        @(negedge clk);
        chk("stray_pmem_read", 128'(bus.pmem_read), 128'(0));
        @(posedge clk); #1;
        access(1'b0, 16'h1230, '0, cyc, wb, wb_a, wb_d, fill_a, rd);
        chk("stray_hit_cycles", 128'(cyc), 128'(1));
        chk("stray_hit_rdata", rd, blk(16'h1230));
        @(negedge clk);
`ifdef L2_PERF_COUNTERS_EN
        chk("cnt_hit2",  128'(hit_count),  128'(2));
        chk("cnt_miss2", 128'(miss_count), 128'(1));
`else
        chk("cnt_hit2",  128'(hit_count),  128'(0));
        chk("cnt_miss2", 128'(miss_count), 128'(0));
`endif

        chk("pmem_rd_wr_overlap", 128'(both_cnt), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
